// File: rtl/gppram_pkg.sv
// rtl/gppram_pkg.sv - shared constants, clear FSM states and depth helper for gppram_dp
package gppram_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int ADDR_W_DEF     = 11;
    localparam int CPU_ADDR_W_DEF = 13;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } clr_state_t;

    // Number of words addressed by an array address of the given width
    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/gppram_array.sv
// rtl/gppram_array.sv - raw synchronous single-port read-first block RAM
module gppram_array
    import gppram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int DEPTH = depth_of(ADDR_W);

    (* ram_style = "block" *) logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_rdata;

    // Read-first port: the output register captures the word before any write lands
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            r_rdata <= r_mem[i_addr];
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/gppram_dp.sv
// rtl/gppram_dp.sv - mirrored CPU work RAM with read-only DMA port; optional clear sweep via GPPRAM_INIT_CLEAR_EN
module gppram_dp
    import gppram_pkg::*;
#(
    parameter int                 DATA_W      = DATA_W_DEF,
    parameter int                 ADDR_W      = ADDR_W_DEF,
    parameter int                 CPU_ADDR_W  = CPU_ADDR_W_DEF,
    parameter logic [DATA_W-1:0]  CLEAR_VALUE = '0
) (
    input  logic                  i_clk_cpu,
    input  logic                  i_reset,
    input  logic                  i_ce,
    input  logic                  i_rnw,
    input  logic [CPU_ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0]     i_data_in,
    output logic [DATA_W-1:0]     o_data_out,
    output logic                  o_valid,
    input  logic                  i_dma_req,
    input  logic [ADDR_W-1:0]     i_dma_addr,
    output logic                  o_dma_ack,
    output logic [DATA_W-1:0]     o_dma_data,
    output logic                  o_dma_valid,
    output logic                  o_busy
);

    logic [ADDR_W-1:0] w_cpu_idx;
    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_cpu_acc;
    logic              w_grant;
    logic              w_arr_en;
    logic              w_arr_we;
    logic [ADDR_W-1:0] w_arr_addr;
    logic [DATA_W-1:0] w_arr_wdata;
    logic [DATA_W-1:0] w_rdata;
    logic              w_unused_addr_hi;

    logic              r_cpu_q;
    logic              r_rd_q;
    logic              r_dma_q;
    logic [DATA_W-1:0] r_cpu_hold;
    logic [DATA_W-1:0] r_dma_hold;

    // Upper CPU address bits only select a mirror, so they never reach the array
    assign w_cpu_idx        = i_addr[ADDR_W-1:0];
    assign w_unused_addr_hi = ^{i_addr, CLEAR_VALUE};

`ifdef GPPRAM_INIT_CLEAR_EN
    clr_state_t        r_state;
    logic [ADDR_W-1:0] r_cnt;

    // Clear sweep: one word per cycle from 0 up to DEPTH-1, restarted by every reset
    always_ff @(posedge i_clk_cpu) begin
        if (i_reset) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == {ADDR_W{1'b1}}) begin
                r_state <= ST_READY;
            end
        end
    end

    assign w_busy     = (r_state == ST_CLEAR);
    assign w_clr_we   = w_busy & ~i_reset;
    assign w_clr_addr = r_cnt;
`else
    assign w_busy     = 1'b0;
    assign w_clr_we   = 1'b0;
    assign w_clr_addr = '0;
`endif

    // CPU always wins; DMA only gets idle cycles, and nothing is granted during reset
    assign w_cpu_acc = i_ce & ~w_busy & ~i_reset;
    assign w_grant   = i_dma_req & ~i_ce & ~w_busy & ~i_reset;

    // Single array port shared by the clear sweep, the CPU and the DMA reader
    always_comb begin
        w_arr_en    = 1'b0;
        w_arr_we    = 1'b0;
        w_arr_addr  = w_cpu_idx;
        w_arr_wdata = i_data_in;
        if (w_clr_we) begin
            w_arr_en    = 1'b1;
            w_arr_we    = 1'b1;
            w_arr_addr  = w_clr_addr;
            w_arr_wdata = CLEAR_VALUE;
        end else if (w_cpu_acc) begin
            w_arr_en = 1'b1;
            w_arr_we = ~i_rnw;
        end else if (w_grant) begin
            w_arr_en   = 1'b1;
            w_arr_addr = i_dma_addr;
        end
    end

    gppram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .i_clk   (i_clk_cpu),
        .i_en    (w_arr_en),
        .i_we    (w_arr_we),
        .i_addr  (w_arr_addr),
        .i_wdata (w_arr_wdata),
        .o_rdata (w_rdata)
    );

    // Track who owned the array last cycle and keep each port's last word once the array moves on
    always_ff @(posedge i_clk_cpu) begin
        if (i_reset) begin
            r_cpu_q    <= 1'b0;
            r_rd_q     <= 1'b0;
            r_dma_q    <= 1'b0;
            r_cpu_hold <= '0;
            r_dma_hold <= '0;
        end else begin
            r_cpu_q <= w_cpu_acc;
            r_rd_q  <= w_cpu_acc & i_rnw;
            r_dma_q <= w_grant;
            if (r_cpu_q) begin
                r_cpu_hold <= w_rdata;
            end
            if (r_dma_q) begin
                r_dma_hold <= w_rdata;
            end
        end
    end

    assign o_data_out  = r_cpu_q ? w_rdata : r_cpu_hold;
    assign o_dma_data  = r_dma_q ? w_rdata : r_dma_hold;
    assign o_valid     = r_rd_q;
    assign o_dma_valid = r_dma_q;
    assign o_dma_ack   = w_grant;
    assign o_busy      = w_busy;

endmodule

// File: tb/tb_gppram_dp.sv
// tb/tb_gppram_dp.sv - self-checking scoreboard bench for gppram_dp
module tb_gppram_dp;

    localparam int DEPTH = 2048;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        rnw;
    logic [12:0] addr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        valid;
    logic        dreq;
    logic [10:0] daddr;
    logic        dack;
    logic [7:0]  ddata;
    logic        dvalid;
    logic        busy;

    logic [7:0]  model [0:DEPTH-1];
    logic [7:0]  cpu_q [$];
    logic [7:0]  dma_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n;
    int          acks;

    gppram_dp dut (
        .i_clk_cpu   (clk),
        .i_reset     (rst),
        .i_ce        (ce),
        .i_rnw       (rnw),
        .i_addr      (addr),
        .i_data_in   (din),
        .o_data_out  (dout),
        .o_valid     (valid),
        .i_dma_req   (dreq),
        .i_dma_addr  (daddr),
        .o_dma_ack   (dack),
        .o_dma_data  (ddata),
        .o_dma_valid (dvalid),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then score any read data the DUT presented
    task automatic step();
        @(posedge clk);
        #1;
        if (valid === 1'b1) begin
            if (cpu_q.size() == 0) check("cpu_unexpected_valid", 1, 0);
            else check("cpu_read", {24'd0, dout}, {24'd0, cpu_q.pop_front()});
        end
        if (dvalid === 1'b1) begin
            if (dma_q.size() == 0) check("dma_unexpected_valid", 1, 0);
            else check("dma_read", {24'd0, ddata}, {24'd0, dma_q.pop_front()});
        end
    endtask

    task automatic cpu_wr(input logic [12:0] a, input logic [7:0] d);
        ce = 1'b1; rnw = 1'b0; addr = a; din = d;
        model[a[10:0]] = d;
        step();
        ce = 1'b0;
    endtask

    task automatic cpu_rd(input logic [12:0] a);
        ce = 1'b1; rnw = 1'b1; addr = a;
        cpu_q.push_back(model[a[10:0]]);
        step();
        ce = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
        rst = 1'b1; ce = 1'b0; rnw = 1'b1; addr = '0; din = '0; dreq = 1'b0; daddr = '0;
        step();
        step();
        check("rst_valid", valid, 0);
        check("rst_dout", dout, 0);
        check("rst_dvalid", dvalid, 0);
        check("rst_ddata", ddata, 0);
        check("rst_dack", dack, 0);
`ifdef GPPRAM_INIT_CLEAR_EN
        check("rst_busy", busy, 1);
        // Sweep length with a dropped CPU write at cycle 100
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 5000) begin
            ce = (n == 100); rnw = 1'b0; addr = 13'h0005; din = 8'hFF;
            n++;
            step();
        end
        ce = 1'b0;
        check("sweep_len", n, 2048);
        check("busy_dout_zero", dout, 0);
        cpu_rd(13'h0005);
        // Reset at sweep cycle 1000 restarts the full sweep
        rst = 1'b1; step(); rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 1000) begin n++; step(); end
        rst = 1'b1; step(); rst = 1'b0;
        check("midsweep_busy", busy, 1);
        n = 0;
        dreq = 1'b1; daddr = 11'h040;
        while (busy === 1'b1 && n < 5000) begin
            if (n == 50) check("busy_no_ack", dack, 0);
            n++;
            step();
        end
        dreq = 1'b0;
        check("midsweep_len", n, 2048);
`else
        check("rst_busy", busy, 0);
        rst = 1'b0;
`endif
        // Mirroring
        cpu_wr(13'h0123, 8'hA5);
        cpu_rd(13'h0923);
        cpu_rd(13'h1123);
        cpu_rd(13'h1923);
        // Read-first
        cpu_wr(13'h0010, 8'h00);
        cpu_wr(13'h0010, 8'h3C);
        check("rf_valid", valid, 0);
        check("rf_old", dout, 8'h00);
        cpu_rd(13'h0010);
        step();
        check("idle_hold", dout, 8'h3C);
        // Arbitration: CPU reads starve the DMA request
        cpu_wr(13'h0040, 8'h77);
        dreq = 1'b1; daddr = 11'h040;
        for (int i = 0; i < 3; i++) begin
            ce = 1'b1; rnw = 1'b1; addr = 13'h0923;
            cpu_q.push_back(model[11'h123]);
            #1;
            check("arb_no_ack", dack, 0);
            step();
        end
        ce = 1'b0;
        #1;
        check("arb_ack", dack, 1);
        dma_q.push_back(model[11'h040]);
        step();
        dreq = 1'b0;
        step();
        check("dma_hold", ddata, 8'h77);
        // DMA burst
        for (int i = 0; i < 256; i++) cpu_wr(13'h0200 + 13'(i), 8'(i) ^ 8'h5A);
        acks = 0;
        for (int i = 0; i < 256; i++) begin
            dreq = 1'b1; daddr = 11'h200 + 11'(i);
            #1;
            if (dack === 1'b1) acks++;
            dma_q.push_back(model[daddr]);
            step();
        end
        dreq = 1'b0;
        step();
        check("burst_acks", acks, 256);
        // Reset with CPU read and DMA request pending
        ce = 1'b1; rnw = 1'b1; addr = 13'h0123; dreq = 1'b1; daddr = 11'h040; rst = 1'b1;
        step();
        check("rstmid_valid", valid, 0);
        check("rstmid_dvalid", dvalid, 0);
        check("rstmid_dout", dout, 0);
        rst = 1'b0; ce = 1'b0; dreq = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 5000) begin n++; step(); end
        dreq = 1'b1; daddr = 11'h040;
        #1;
        check("rstmid_ack", dack, 1);
        dma_q.push_back(model[11'h040]);
        step();
        dreq = 1'b0;
        step();
        step();
        check("cpu_q_empty", cpu_q.size(), 0);
        check("dma_q_empty", dma_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
